// File: rtl/regfile_sb_if.sv
// Bundle of the register file's writeback, read, issue and scoreboard signals.
// The core side uses the master modport; the register file uses slave.
interface regfile_sb_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2
);
  logic                         wen;
  logic [ADDR_WIDTH-1:0]        waddr;
  logic [DATA_WIDTH-1:0]        wdata;
  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]            rd_busy;
  logic                         iss_valid;
  logic [ADDR_WIDTH-1:0]        iss_addr;
  logic                         flush;
  logic [ADDR_WIDTH:0]          busy_cnt;

  modport master (
    output wen, waddr, wdata, rd_addr, iss_valid, iss_addr, flush,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  wen, waddr, wdata, rd_addr, iss_valid, iss_addr, flush,
    output rd_data, rd_busy, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with NUM_RD combinational read ports, optional
// write-to-read bypass and a per-register busy scoreboard with population count.
module regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  regfile_sb_if.slave   bus
);
  localparam int DEPTH    = 1 << ADDR_WIDTH;
  localparam int CNT_W    = ADDR_WIDTH + 1;
  localparam bit HAS_ZERO = (ZERO_REG != 0);
  localparam bit HAS_BYP  = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] rf [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_nxt;
  logic [CNT_W-1:0]      busy_cnt;
  logic                  wr_en;
  logic                  iss_en;
  logic                  cnt_inc;
  logic                  cnt_dec;

  // Writes and issues aimed at the hardwired zero register are filtered here,
  // so busy[0] can never be set and the count never sees them.
  always_comb begin
    wr_en    = bus.wen && !(HAS_ZERO && (bus.waddr == '0));
    iss_en   = bus.iss_valid && !(HAS_ZERO && (bus.iss_addr == '0));
    cnt_inc  = iss_en && !busy[bus.iss_addr];
    cnt_dec  = wr_en && busy[bus.waddr] &&
               !(iss_en && (bus.iss_addr == bus.waddr));
    busy_nxt = busy;
    if (wr_en)  busy_nxt[bus.waddr]    = 1'b0;
    if (iss_en) busy_nxt[bus.iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else if (bus.flush) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
    end
  end

  // The data write still happens under flush; only the scoreboard is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[bus.waddr] <= bus.wdata;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    logic                  zero_hit;
    logic                  byp_hit;

    assign a        = bus.rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign zero_hit = HAS_ZERO && (a == '0);
    assign byp_hit  = HAS_BYP && bus.wen && (bus.waddr == a);

    assign bus.rd_data[g*DATA_WIDTH +: DATA_WIDTH] =
      zero_hit ? '0 : (byp_hit ? bus.wdata : rf[a]);
    assign bus.rd_busy[g] = !zero_hit && busy[a] && !byp_hit;
  end

  assign bus.busy_cnt = busy_cnt;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default build, a no-bypass build sharing its
// inputs, and a wide 4-port build without a zero register.
module tb_regfile_sb;
  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;

  regfile_sb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2)) ifa ();
  regfile_sb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2)) ifb ();
  regfile_sb_if #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .NUM_RD(4)) ifw ();

  regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1))
    u_nb (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  regfile_sb #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .NUM_RD(4), .BYPASS(1), .ZERO_REG(0))
    u_wide (.clk(clk), .rst_n(rst_n), .bus(ifw.slave));

  assign ifb.wen       = ifa.wen;
  assign ifb.waddr     = ifa.waddr;
  assign ifb.wdata     = ifa.wdata;
  assign ifb.rd_addr   = ifa.rd_addr;
  assign ifb.iss_valid = ifa.iss_valid;
  assign ifb.iss_addr  = ifa.iss_addr;
  assign ifb.flush     = ifa.flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setrd(input logic [4:0] a0, input logic [4:0] a1);
    ifa.rd_addr = {a1, a0};
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifa.wen = 1'b1; ifa.waddr = 5'd3; ifa.wdata = 32'hDEAD;
    setrd(5'd3, 5'd0);
    step();
    rst_n = 1'b1;
    ifa.wen = 1'b0;
    #1;
    vecs++; if (ifa.rd_data[31:0] !== 32'h0) begin errs++;
      $display("FAIL reset_rd0: got %h, expected %h", ifa.rd_data[31:0], 32'h0); end
    vecs++; if (ifa.busy_cnt !== 6'd0) begin errs++;
      $display("FAIL reset_cnt: got %0d, expected 0", ifa.busy_cnt); end
    vecs++; if (ifa.rd_busy !== 2'b00) begin errs++;
      $display("FAIL reset_busy: got %b, expected 00", ifa.rd_busy); end
    vecs++; if (ifb.rd_data[31:0] !== 32'h0) begin errs++;
      $display("FAIL reset_nb_rd0: got %h, expected %h", ifb.rd_data[31:0], 32'h0); end
    vecs++; if (ifw.busy_cnt !== 5'd0) begin errs++;
      $display("FAIL reset_wide_cnt: got %0d, expected 0", ifw.busy_cnt); end
    // Register 0 ignores writes and bypass.
    ifa.wen = 1'b1; ifa.waddr = 5'd0; ifa.wdata = 32'h1234;
    setrd(5'd0, 5'd0);
    vecs++; if (ifa.rd_data[31:0] !== 32'h0) begin errs++;
      $display("FAIL zero_byp: got %h, expected %h", ifa.rd_data[31:0], 32'h0); end
    step();
    ifa.wen = 1'b0;
    #1;
    vecs++; if (ifa.rd_data !== 64'h0) begin errs++;
      $display("FAIL zero_wr: got %h, expected %h", ifa.rd_data, 64'h0); end
  endtask

  task automatic test_write_read();
    ifa.wen = 1'b1; ifa.waddr = 5'd5; ifa.wdata = 32'hA5A5_0001;
    step();
    ifa.waddr = 5'd7; ifa.wdata = 32'h1111_2222;
    step();
    ifa.wen = 1'b0;
    setrd(5'd5, 5'd5);
    vecs++; if (ifa.rd_data !== {32'hA5A5_0001, 32'hA5A5_0001}) begin errs++;
      $display("FAIL wr_rd_x5: got %h, expected %h", ifa.rd_data, {32'hA5A5_0001, 32'hA5A5_0001}); end
    ifa.wen = 1'b1; ifa.waddr = 5'd7; ifa.wdata = 32'h0BAD_CAFE;
    setrd(5'd5, 5'd7);
    vecs++; if (ifa.rd_data[63:32] !== 32'h0BAD_CAFE) begin errs++;
      $display("FAIL bypass_on: got %h, expected %h", ifa.rd_data[63:32], 32'h0BAD_CAFE); end
    vecs++; if (ifb.rd_data[63:32] !== 32'h1111_2222) begin errs++;
      $display("FAIL bypass_off: got %h, expected %h", ifb.rd_data[63:32], 32'h1111_2222); end
    step();
    ifa.wen = 1'b0;
    #1;
    vecs++; if (ifb.rd_data[63:32] !== 32'h0BAD_CAFE) begin errs++;
      $display("FAIL nb_after_wr: got %h, expected %h", ifb.rd_data[63:32], 32'h0BAD_CAFE); end
  endtask

  task automatic test_scoreboard();
    ifa.iss_valid = 1'b1; ifa.iss_addr = 5'd10;
    setrd(5'd10, 5'd0);
    vecs++; if (ifa.rd_busy !== 2'b00) begin errs++;
      $display("FAIL iss_same_cycle: got %b, expected 00", ifa.rd_busy); end
    step();
    ifa.iss_valid = 1'b0;
    #1;
    vecs++; if (ifa.rd_busy !== 2'b01) begin errs++;
      $display("FAIL iss_busy: got %b, expected 01", ifa.rd_busy); end
    vecs++; if (ifa.busy_cnt !== 6'd1) begin errs++;
      $display("FAIL iss_cnt: got %0d, expected 1", ifa.busy_cnt); end
    ifa.wen = 1'b1; ifa.waddr = 5'd10; ifa.wdata = 32'h0000_00AA;
    #1;
    vecs++; if (ifa.rd_busy[0] !== 1'b0) begin errs++;
      $display("FAIL wb_byp_busy: got %b, expected 0", ifa.rd_busy[0]); end
    vecs++; if (ifb.rd_busy[0] !== 1'b1) begin errs++;
      $display("FAIL wb_nb_busy: got %b, expected 1", ifb.rd_busy[0]); end
    step();
    ifa.wen = 1'b0;
    #1;
    vecs++; if (ifa.busy_cnt !== 6'd0) begin errs++;
      $display("FAIL wb_cnt: got %0d, expected 0", ifa.busy_cnt); end
    // Issue to register 0 is dropped.
    ifa.iss_valid = 1'b1; ifa.iss_addr = 5'd0;
    step();
    ifa.iss_valid = 1'b0;
    #1;
    vecs++; if (ifa.busy_cnt !== 6'd0) begin errs++;
      $display("FAIL iss_zero_cnt: got %0d, expected 0", ifa.busy_cnt); end
  endtask

  task automatic test_simultaneous();
    ifa.iss_valid = 1'b1; ifa.iss_addr = 5'd4;
    step();
    ifa.wen = 1'b1; ifa.waddr = 5'd4; ifa.wdata = 32'h44;
    step();
    ifa.wen = 1'b0; ifa.iss_valid = 1'b0;
    setrd(5'd4, 5'd6);
    vecs++; if (ifa.rd_busy !== 2'b01) begin errs++;
      $display("FAIL same_addr_busy: got %b, expected 01", ifa.rd_busy); end
    vecs++; if (ifa.busy_cnt !== 6'd1) begin errs++;
      $display("FAIL same_addr_cnt: got %0d, expected 1", ifa.busy_cnt); end
    ifa.iss_valid = 1'b1; ifa.iss_addr = 5'd6;
    ifa.wen = 1'b1; ifa.waddr = 5'd4; ifa.wdata = 32'h45;
    step();
    ifa.wen = 1'b0; ifa.iss_valid = 1'b0;
    #1;
    vecs++; if (ifa.rd_busy !== 2'b10) begin errs++;
      $display("FAIL swap_busy: got %b, expected 10", ifa.rd_busy); end
    vecs++; if (ifa.busy_cnt !== 6'd1) begin errs++;
      $display("FAIL swap_cnt: got %0d, expected 1", ifa.busy_cnt); end
    // Reissue of a busy register and a write to an idle one leave the count alone.
    ifa.iss_valid = 1'b1; ifa.iss_addr = 5'd6;
    ifa.wen = 1'b1; ifa.waddr = 5'd9; ifa.wdata = 32'h99;
    step();
    ifa.iss_valid = 1'b0;
    ifa.waddr = 5'd6; ifa.wdata = 32'h66;
    #1;
    vecs++; if (ifa.busy_cnt !== 6'd1) begin errs++;
      $display("FAIL reissue_cnt: got %0d, expected 1", ifa.busy_cnt); end
    step();
    ifa.wen = 1'b0;
    #1;
    vecs++; if (ifa.busy_cnt !== 6'd0) begin errs++;
      $display("FAIL drain_cnt: got %0d, expected 0", ifa.busy_cnt); end
  endtask

  task automatic test_flush();
    for (int r = 1; r <= 3; r++) begin
      ifa.iss_valid = 1'b1; ifa.iss_addr = 5'(r);
      step();
    end
    ifa.iss_valid = 1'b0;
    setrd(5'd1, 5'd3);
    vecs++; if (ifa.busy_cnt !== 6'd3) begin errs++;
      $display("FAIL pre_flush_cnt: got %0d, expected 3", ifa.busy_cnt); end
    vecs++; if (ifa.rd_busy !== 2'b11) begin errs++;
      $display("FAIL pre_flush_busy: got %b, expected 11", ifa.rd_busy); end
    ifa.flush = 1'b1;
    ifa.iss_valid = 1'b1; ifa.iss_addr = 5'd8;
    ifa.wen = 1'b1; ifa.waddr = 5'd2; ifa.wdata = 32'h77;
    step();
    ifa.flush = 1'b0; ifa.iss_valid = 1'b0; ifa.wen = 1'b0;
    setrd(5'd8, 5'd2);
    vecs++; if (ifa.busy_cnt !== 6'd0) begin errs++;
      $display("FAIL flush_cnt: got %0d, expected 0", ifa.busy_cnt); end
    vecs++; if (ifa.rd_busy !== 2'b00) begin errs++;
      $display("FAIL flush_busy_82: got %b, expected 00", ifa.rd_busy); end
    vecs++; if (ifa.rd_data[63:32] !== 32'h77) begin errs++;
      $display("FAIL flush_wdata: got %h, expected %h", ifa.rd_data[63:32], 32'h77); end
    setrd(5'd1, 5'd3);
    vecs++; if (ifa.rd_busy !== 2'b00) begin errs++;
      $display("FAIL flush_busy_13: got %b, expected 00", ifa.rd_busy); end
  endtask

  task automatic test_param_sweep();
    logic [63:0] exp_d;
    ifw.wen = 1'b1; ifw.waddr = 4'd0; ifw.wdata = 64'h1;
    step();
    ifw.wen = 1'b0;
    ifw.rd_addr = 16'h0000;
    #1;
    vecs++; if (ifw.rd_data[63:0] !== 64'h1) begin errs++;
      $display("FAIL wide_reg0: got %h, expected %h", ifw.rd_data[63:0], 64'h1); end
    for (int r = 0; r < 16; r++) begin
      ifw.iss_valid = 1'b1; ifw.iss_addr = 4'(r);
      step();
    end
    ifw.iss_valid = 1'b0;
    #1;
    vecs++; if (ifw.busy_cnt !== 5'd16) begin errs++;
      $display("FAIL wide_cnt_full: got %0d, expected 16", ifw.busy_cnt); end
    for (int r = 1; r <= 4; r++) begin
      ifw.wen = 1'b1; ifw.waddr = 4'(r); ifw.wdata = 64'hC0DE_0000_0000_0000 | 64'(r);
      step();
    end
    ifw.wen = 1'b0;
    ifw.rd_addr = {4'd4, 4'd3, 4'd2, 4'd1};
    #1;
    for (int p = 0; p < 4; p++) begin
      exp_d = 64'hC0DE_0000_0000_0000 | 64'(p + 1);
      vecs++; if (ifw.rd_data[p*64 +: 64] !== exp_d) begin errs++;
        $display("FAIL wide_port%0d: got %h, expected %h", p, ifw.rd_data[p*64 +: 64], exp_d); end
    end
    vecs++; if (ifw.busy_cnt !== 5'd12) begin errs++;
      $display("FAIL wide_cnt_after: got %0d, expected 12", ifw.busy_cnt); end
    ifw.rd_addr = {4'd5, 4'd4, 4'd15, 4'd1};
    #1;
    vecs++; if (ifw.rd_busy !== 4'b1010) begin errs++;
      $display("FAIL wide_busy: got %b, expected 1010", ifw.rd_busy); end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst_n = 1'b0;
    ifa.wen = 1'b0; ifa.waddr = '0; ifa.wdata = '0; ifa.rd_addr = '0;
    ifa.iss_valid = 1'b0; ifa.iss_addr = '0; ifa.flush = 1'b0;
    ifw.wen = 1'b0; ifw.waddr = '0; ifw.wdata = '0; ifw.rd_addr = '0;
    ifw.iss_valid = 1'b0; ifw.iss_addr = '0; ifw.flush = 1'b0;
    test_reset();
    test_write_read();
    test_scoreboard();
    test_simultaneous();
    test_flush();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
